timer_arm_host: RTL
===================

TIMER_ARM_HOST -- requirements
Module: timer_arm_host

Interface
REQ-001 Parameter DataWidth, default 32, bus data width; only 32 SHALL be legal, with an elaboration-time assertion.
REQ-002 Parameter AddressWidth, default 32, bus address width.
REQ-003 Parameter BaseAddr, default 0, timer base address; registers SHALL be at BaseAddr+0x0 MTIME_LOW, +0x4 MTIME_HIGH, +0x8 MTIMECMP_LOW, +0xC MTIMECMP_HIGH.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 enable_i  input  1  level; high runs periodic arming.
REQ-007 period_i  input  64  tick period in mtime counts; sampled at each compare computation.
REQ-008 tick_o  output  1  one-cycle pulse per timer expiry.
REQ-009 busy_o  output  1  high whenever state is not IDLE.
REQ-010 err_o  output  1  sticky bus-error flag.
REQ-011 req_o  output  1  bus request.
REQ-012 addr_o  output  AddressWidth  bus address.
REQ-013 we_o  output  1  write enable.
REQ-014 be_o  output  DataWidth/8  byte enables.
REQ-015 wdata_o  output  DataWidth  write data.
REQ-016 rvalid_i  input  1  response valid, one per request.
REQ-017 rdata_i  input  DataWidth  read data, valid with rvalid_i.
REQ-018 err_i  input  1  response error, valid with rvalid_i.
REQ-019 intr_i  input  1  timer interrupt level.

Function
REQ-020 At most one transaction SHALL be outstanding; req_o SHALL be high for exactly one cycle per transaction, then low until the matching rvalid_i.
REQ-021 addr_o, we_o, be_o and wdata_o SHALL be held stable from the req_o cycle through the rvalid_i cycle.
REQ-022 be_o SHALL be all ones; for reads, we_o=0 and wdata_o=0.
REQ-023 The block SHALL accept rvalid_i any cycle at least one cycle after req_o; the next req_o SHALL be issued no earlier than the cycle after rvalid_i.
REQ-024 State IDLE: when enable_i=1, go to RD_HI1.
REQ-025 RD_HI1: read MTIME_HIGH into hi1. RD_LO: read MTIME_LOW into lo. RD_HI2: read MTIME_HIGH into hi2.
REQ-026 If hi2 != hi1, return to RD_HI1 (rollover retry). Otherwise compute cmp_q = {hi1,lo} + period, then go to WR_MAX.
REQ-027 The compare sum SHALL be 64-bit modulo 2^64; a period_i of 0 SHALL be treated as 1.
REQ-028 WR_MAX: write MTIMECMP_LOW=0xFFFFFFFF. WR_HI: write MTIMECMP_HIGH=cmp_q[63:32]. WR_LO: write MTIMECMP_LOW=cmp_q[31:0]. Then go to WAIT_INTR.
REQ-029 WAIT_INTR: on intr_i=1, assert tick_o for one cycle, set cmp_q = cmp_q + period (REQ-027 rules), and go to WR_MAX without re-reading mtime.
REQ-030 If intr_i and enable_i=0 occur in the same cycle in WAIT_INTR, the tick SHALL still pulse, then the block SHALL go to IDLE.
REQ-031 enable_i=0 in WAIT_INTR SHALL go to IDLE the next cycle.
REQ-032 enable_i=0 in any bus state SHALL complete the outstanding transaction (wait for rvalid_i), then go to IDLE without issuing further requests.
REQ-033 rvalid_i with err_i=1 in any state SHALL set err_o and go to ERROR; ERROR issues no requests.
REQ-034 ERROR SHALL be left only when enable_i=0, going to IDLE, which clears err_o.
REQ-035 rvalid_i received with no transaction outstanding SHALL be ignored.

Reset
REQ-036 On reset: state IDLE; req_o, we_o, tick_o, busy_o and err_o = 0; addr_o = BaseAddr; wdata_o = 0; be_o all ones; cmp_q = 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it immediately; a late rvalid_i after reset SHALL be ignored per REQ-035.

Verification
REQ-038 Bench: mtime=0x00000000_FFFFFFF0, period 0x20, enable -> reads 0x4, 0x0, 0x4, then writes 0x8<=0xFFFFFFFF, 0xC<=0x00000001, 0x8<=0x00000010.
REQ-039 Bench: reads return hi=0, lo=0xFFFFFFFF, hi=1 -> second read sequence issued; compare based on that retry.
REQ-040 Bench: after REQ-038, intr_i raised -> one tick_o pulse, writes 0x8<=0xFFFFFFFF, 0xC<=1, 0x8<=0x30, no mtime reads.
REQ-041 Bench: err_i=1 on MTIME_LOW response -> err_o=1, no req_o while enable_i=1; enable_i=0 -> IDLE, err_o=0.
REQ-042 Bench: enable_i dropped during WR_HI with rvalid_i delayed 3 cycles -> no req_o after that response; busy_o falls one cycle later.
REQ-043 Bench: rst_ni pulsed while a read is outstanding -> all outputs at reset values; stray rvalid_i ignored.

Source files
------------

// File: rtl/timer_arm_host.sv
// timer_arm_host: bus master that periodically arms a memory-mapped mtime/mtimecmp timer.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable_i, period_i       run control and tick period (mtime counts, 0 treated as 1)
//   tick_o, busy_o, err_o    expiry pulse, non-idle flag, sticky bus-error flag
//   req_o, addr_o, we_o,     single-outstanding bus request and its payload
//   be_o, wdata_o
//   rvalid_i, rdata_i, err_i bus response
//   intr_i                   timer interrupt level
module timer_arm_host #(
    parameter int unsigned                  DataWidth    = 32,
    parameter int unsigned                  AddressWidth = 32,
    parameter logic [AddressWidth-1:0]      BaseAddr     = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [63:0]             period_i,
    output logic                    tick_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    req_o,
    output logic [AddressWidth-1:0] addr_o,
    output logic                    we_o,
    output logic [DataWidth/8-1:0]  be_o,
    output logic [DataWidth-1:0]    wdata_o,
    input  logic                    rvalid_i,
    input  logic [DataWidth-1:0]    rdata_i,
    input  logic                    err_i,
    input  logic                    intr_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    localparam logic [AddressWidth-1:0] AddrTimeLo = BaseAddr + AddressWidth'(32'h0);
    localparam logic [AddressWidth-1:0] AddrTimeHi = BaseAddr + AddressWidth'(32'h4);
    localparam logic [AddressWidth-1:0] AddrCmpLo  = BaseAddr + AddressWidth'(32'h8);
    localparam logic [AddressWidth-1:0] AddrCmpHi  = BaseAddr + AddressWidth'(32'hC);

    // Only a 32-bit data bus matches the 32-bit timer register halves.
    if (DataWidth != 32) begin : g_bad_width
        $error("timer_arm_host: DataWidth must be 32");
    end

    typedef enum logic [3:0] {
        IDLE, RD_HI1, RD_LO, RD_HI2, WR_MAX, WR_HI, WR_LO, WAIT_INTR, ERROR
    } state_e;

    state_e                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    req_q, req_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic [BeWidth-1:0]      be_q;
    logic                    tick_q, tick_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [DataWidth-1:0]    hi1_q, hi1_d;
    logic [DataWidth-1:0]    lo_q, lo_d;
    logic [63:0]             cmp_q, cmp_d;

    logic [63:0]             period_eff;
    logic                    resp;
    logic                    bus_state;
    logic [AddressWidth-1:0] iss_addr;
    logic                    iss_we;
    logic [DataWidth-1:0]    iss_wdata;

    // A zero period would re-arm at the current time; clamp to one count.
    assign period_eff = (period_i == 64'd0) ? 64'd1 : period_i;
    // Responses only count while a request is outstanding; strays are dropped.
    assign resp       = pend_q && rvalid_i;
    assign bus_state  = (state_q == RD_HI1) || (state_q == RD_LO) || (state_q == RD_HI2) ||
                        (state_q == WR_MAX) || (state_q == WR_HI) || (state_q == WR_LO);

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= BaseAddr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            hi1_q   <= '0;
            lo_q    <= '0;
            cmp_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= '1;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            hi1_q   <= hi1_d;
            lo_q    <= lo_d;
            cmp_q   <= cmp_d;
        end
    end

    // Next-state, bus issue and response handling.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        req_d     = 1'b0;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        tick_d    = 1'b0;
        err_d     = err_q;
        hi1_d     = hi1_q;
        lo_d      = lo_q;
        cmp_d     = cmp_q;
        iss_addr  = AddrTimeLo;
        iss_we    = 1'b0;
        iss_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = RD_HI1;
            end
            RD_HI1: begin
                iss_addr = AddrTimeHi;
                if (resp) begin
                    hi1_d   = rdata_i;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                iss_addr = AddrTimeLo;
                if (resp) begin
                    lo_d    = rdata_i;
                    state_d = RD_HI2;
                end
            end
            RD_HI2: begin
                iss_addr = AddrTimeHi;
                // A changed high word means the low read straddled a rollover.
                if (resp) begin
                    if (rdata_i != hi1_q) begin
                        state_d = RD_HI1;
                    end else begin
                        cmp_d   = {hi1_q, lo_q} + period_eff;
                        state_d = WR_MAX;
                    end
                end
            end
            WR_MAX: begin
                // Park the low half high so no spurious match occurs mid-update.
                iss_addr  = AddrCmpLo;
                iss_we    = 1'b1;
                iss_wdata = '1;
                if (resp) state_d = WR_HI;
            end
            WR_HI: begin
                iss_addr  = AddrCmpHi;
                iss_we    = 1'b1;
                iss_wdata = DataWidth'(cmp_q[63:32]);
                if (resp) state_d = WR_LO;
            end
            WR_LO: begin
                iss_addr  = AddrCmpLo;
                iss_we    = 1'b1;
                iss_wdata = DataWidth'(cmp_q[31:0]);
                if (resp) state_d = WAIT_INTR;
            end
            WAIT_INTR: begin
                if (intr_i) begin
                    tick_d  = 1'b1;
                    cmp_d   = cmp_q + period_eff;
                    state_d = enable_i ? WR_MAX : IDLE;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared bus handshake: issue once per state, retire on response.
        if (bus_state) begin
            if (resp) begin
                pend_d = 1'b0;
                if (err_i) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end else if (!pend_q) begin
                if (enable_i) begin
                    req_d   = 1'b1;
                    pend_d  = 1'b1;
                    addr_d  = iss_addr;
                    we_d    = iss_we;
                    wdata_d = iss_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign busy_d  = (state_d != IDLE);

    assign tick_o  = tick_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;
    assign req_o   = req_q;
    assign addr_o  = addr_q;
    assign we_o    = we_q;
    assign be_o    = be_q;
    assign wdata_o = wdata_q;

endmodule
